// File: rtl/ervp_iterative_normalizer.sv
// ervp_iterative_normalizer
//
// Purpose: multi-cycle normalizer that finds the left-shift count of a data
// word and produces the normalized word. With SIGNED_DATA=0 it counts
// leading zeros. With SIGNED_DATA=1 it counts leading bits equal to the sign
// bit, not counting the sign bit itself. One binary-search step is made per
// cycle, from the largest step size down to 1. The count is clamped to
// BW_DATA-1, so all-zero (or all-equal) words report BW_DATA-1.
//
// Ports:
//   clk                  clock, rising edge
//   rstnn                asynchronous active-low reset
//   input_valid/ready    input handshake; ready is high only in IDLE
//   input_data           word to normalize
//   output_valid/ready   output handshake; valid is high only in DONE
//   output_data          normalized word
//   output_shift_amount  number of left shifts applied (always >= 0)
//   output_zero          input was all zeros (unsigned) / all equal (signed)
//
// Optional feature macro: ERVP_NORMALIZER_ZERO_SHORTCUT_EN
//   When defined, an all-zero / all-equal word skips the search and goes
//   straight to DONE with the same result the full search would produce.

module ervp_iterative_normalizer #(
    parameter int BW_DATA         = 32,
    parameter int BW_SHIFT_AMOUNT = 6,
    parameter int SIGNED_DATA     = 0
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic                       input_valid,
    output logic                       input_ready,
    input  logic [BW_DATA-1:0]         input_data,
    output logic                       output_valid,
    input  logic                       output_ready,
    output logic [BW_DATA-1:0]         output_data,
    output logic [BW_SHIFT_AMOUNT-1:0] output_shift_amount,
    output logic                       output_zero
);

    localparam int NUM_STEPS = $clog2(BW_DATA);
    localparam int IDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int MAX_COUNT = BW_DATA - 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                     state;
    logic [BW_DATA-1:0]         work;
    logic [BW_SHIFT_AMOUNT-1:0] count;
    logic [IDX_W-1:0]           step_idx;
    logic                       steps_done;
    logic                       zero_latched;

    int                         step_size;
    logic [BW_DATA-1:0]         top_bits;
    logic [BW_DATA-1:0]         ones_mask;
    logic                       take_step;
    logic                       input_is_zero;

    // Decide whether the current step is taken. The signed test looks at
    // s+1 bits because the sign bit itself must survive the shift. The clamp
    // keeps the count at BW_DATA-1 for all-zero / all-equal words, which is
    // also what makes non-power-of-two widths come out right.
    always_comb begin
        step_size = 1 << int'(step_idx);
        top_bits  = '0;
        ones_mask = '0;
        take_step = 1'b0;
        if (SIGNED_DATA != 0) begin
            top_bits  = work >> (MAX_COUNT - step_size);
            ones_mask = {BW_DATA{1'b1}} >> (MAX_COUNT - step_size);
            take_step = (top_bits == '0) || (top_bits == ones_mask);
        end else begin
            top_bits  = work >> (BW_DATA - step_size);
            take_step = (top_bits == '0);
        end
        if (int'(count) + step_size > MAX_COUNT) begin
            take_step = 1'b0;
        end
    end

    // Zero detection on the word being offered, latched at acceptance.
    always_comb begin
        input_is_zero = (input_data == '0);
        if ((SIGNED_DATA != 0) && (input_data == '1)) begin
            input_is_zero = 1'b1;
        end
    end

    // Control FSM and datapath registers. work and count double as the
    // output registers, so they hold steady through DONE. The search runs
    // NUM_STEPS cycles; one more BUSY cycle (steps_done set) registers the
    // move into DONE.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state        <= IDLE;
            input_ready  <= 1'b0;
            output_valid <= 1'b0;
            work         <= '0;
            count        <= '0;
            step_idx     <= '0;
            steps_done   <= 1'b0;
            zero_latched <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    input_ready <= 1'b1;
                    if (input_valid && input_ready) begin
                        input_ready  <= 1'b0;
                        work         <= input_data;
                        count        <= '0;
                        step_idx     <= IDX_W'(NUM_STEPS - 1);
                        steps_done   <= 1'b0;
                        zero_latched <= input_is_zero;
`ifdef ERVP_NORMALIZER_ZERO_SHORTCUT_EN
                        if (input_is_zero) begin
                            state        <= DONE;
                            output_valid <= 1'b1;
                            work         <= input_data << MAX_COUNT;
                            count        <= BW_SHIFT_AMOUNT'(MAX_COUNT);
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (steps_done) begin
                        state        <= DONE;
                        output_valid <= 1'b1;
                    end else begin
                        if (take_step) begin
                            work  <= work << step_size;
                            count <= count + BW_SHIFT_AMOUNT'(step_size);
                        end
                        if (step_idx == '0) begin
                            steps_done <= 1'b1;
                        end else begin
                            step_idx <= step_idx - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (output_ready) begin
                        state        <= IDLE;
                        output_valid <= 1'b0;
                        input_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    input_ready  <= 1'b0;
                    output_valid <= 1'b0;
                end
            endcase
        end
    end

    assign output_data         = work;
    assign output_shift_amount = count;
    assign output_zero         = zero_latched;

endmodule
